// File: rtl/ioctl_upload_responder.sv
// HPS ioctl upload responder: requests an upload, then answers each ioctl_rd with the byte fetched from core RAM.
// Optional UPLOAD_CHECKSUM_EN adds a modulo-256 checksum of the bytes HPS consumed.
module ioctl_upload_responder #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned RAM_LAT      = 1,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              upload_trig,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_upload_req,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
`ifdef UPLOAD_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              overrun
);

  localparam int unsigned FA_W  = 26;
  localparam int unsigned BC_W  = ADDR_W + 1;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned HI_W  = FA_W - ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FETCH,
    S_WAIT,
    S_READY
  } state_t;

  state_t            state_q;
  logic              upload_prev_q;
  logic              req_q;
  logic [7:0]        din_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              busy_q;
  logic              done_q;
  logic [BC_W-1:0]   byte_count_q;
  logic              overrun_q;
  logic              oor_q;
  logic              pend_q;
  logic [FA_W-1:0]   pend_addr_q;
  logic [CNT_W-1:0]  lat_cnt_q;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]        checksum_q;
`endif

  logic              idx_match_c;
  logic              active_c;
  logic              end_c;
  logic              in_xfer_c;
  logic              strobe_c;
  logic              latch_c;
  logic [FA_W-1:0]   strobe_addr_c;
  logic              launch_c;
  logic [FA_W-1:0]   launch_addr_c;
  logic              in_range_c;

  assign idx_match_c   = (ioctl_index == UPLOAD_INDEX);
  assign active_c      = ioctl_upload & idx_match_c;
  assign end_c         = upload_prev_q & ~ioctl_upload & (state_q != S_IDLE);
  assign in_xfer_c     = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_READY);
  assign strobe_c      = ioctl_rd & idx_match_c & in_xfer_c;
  assign strobe_addr_c = FA_W'(ioctl_addr) + FA_W'(1);
  assign latch_c       = (state_q == S_WAIT) && (lat_cnt_q == CNT_W'(RAM_LAT));
  // Range check on the full-width address so that last+1 reports FF instead of wrapping.
  assign in_range_c    = (launch_addr_c[FA_W-1:ADDR_W] == HI_W'(0));

  // Decide whether a RAM fetch starts at this edge and from which address.
  always_comb begin
    launch_c      = 1'b0;
    launch_addr_c = '0;
    if (!end_c) begin
      case (state_q)
        S_REQ: begin
          if (active_c) begin
            launch_c      = 1'b1;
            launch_addr_c = '0;
          end
        end
        S_READY: begin
          if (strobe_c) begin
            launch_c      = 1'b1;
            launch_addr_c = strobe_addr_c;
          end
        end
        S_WAIT: begin
          if (latch_c && (pend_q || strobe_c)) begin
            launch_c      = 1'b1;
            launch_addr_c = strobe_c ? strobe_addr_c : pend_addr_q;
          end
        end
        default: begin
          launch_c      = 1'b0;
          launch_addr_c = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      upload_prev_q <= 1'b0;
      req_q         <= 1'b0;
      din_q         <= 8'hFF;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      byte_count_q  <= '0;
      overrun_q     <= 1'b0;
      oor_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
      lat_cnt_q     <= '0;
`ifdef UPLOAD_CHECKSUM_EN
      checksum_q    <= 8'h00;
`endif
    end else begin
      upload_prev_q <= ioctl_upload;
      done_q        <= 1'b0;
      mem_rd_q      <= 1'b0;

      // A counted strobe consumes the byte currently on ioctl_din.
      if (strobe_c) begin
        if (byte_count_q != {BC_W{1'b1}}) begin
          byte_count_q <= byte_count_q + BC_W'(1);
        end
`ifdef UPLOAD_CHECKSUM_EN
        checksum_q <= checksum_q + din_q;
`endif
        if (state_q != S_READY) begin
          overrun_q <= 1'b1;
        end
        if ((state_q != S_READY) && !launch_c) begin
          pend_q      <= 1'b1;
          pend_addr_q <= strobe_addr_c;
        end
      end

      if (end_c) begin
        state_q <= S_IDLE;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        req_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (upload_trig) begin
              state_q      <= S_REQ;
              busy_q       <= 1'b1;
              req_q        <= 1'b1;
              byte_count_q <= '0;
              overrun_q    <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
              checksum_q   <= 8'h00;
`endif
            end
          end
          S_REQ: begin
            if (active_c) begin
              req_q <= 1'b0;
            end
          end
          S_FETCH: begin
            state_q   <= S_WAIT;
            lat_cnt_q <= CNT_W'(1);
          end
          S_WAIT: begin
            if (latch_c) begin
              din_q   <= oor_q ? 8'hFF : mem_q;
              state_q <= S_READY;
            end else begin
              lat_cnt_q <= lat_cnt_q + CNT_W'(1);
            end
          end
          S_READY: begin
            state_q <= S_READY;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase

        if (launch_c) begin
          state_q    <= S_FETCH;
          mem_rd_q   <= in_range_c & idx_match_c;
          mem_addr_q <= ADDR_W'(launch_addr_c);
          oor_q      <= ~(in_range_c & idx_match_c);
          pend_q     <= 1'b0;
        end
      end
    end
  end

  assign ioctl_upload_req = req_q;
  assign ioctl_din        = din_q;
  assign mem_addr         = mem_addr_q;
  assign mem_rd           = mem_rd_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign byte_count       = byte_count_q;
  assign overrun          = overrun_q;
`ifdef UPLOAD_CHECKSUM_EN
  assign checksum         = checksum_q;
`endif

endmodule
